// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order through a ping-pong
// buffer, with a valid/ready output stage and a last-bin marker.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LENGTH = 16,
  parameter int LOG2_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_img,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_img,
  output logic [LOG2_LEN-1:0]   out_idx,
  output logic                  out_last,
  output logic                  sync_err
);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(SEQ_LENGTH - 1);

  logic [DATA_WIDTH-1:0] mem_real [2][SEQ_LENGTH];
  logic [DATA_WIDTH-1:0] mem_img  [2][SEQ_LENGTH];

  logic [1:0]          bank_full;
  logic                wr_bank, rd_bank;
  logic [LOG2_LEN-1:0] wr_cnt, rd_cnt;
  logic [LOG2_LEN-1:0] wr_idx;
  logic                accept, resync, frame_done, load, rd_done;
  rd_state_t           state, state_next;

  function automatic logic [LOG2_LEN-1:0] bitrev(input logic [LOG2_LEN-1:0] v);
    logic [LOG2_LEN-1:0] r;
    for (int i = 0; i < LOG2_LEN; i++) r[i] = v[LOG2_LEN-1-i];
    return r;
  endfunction

  // An in_sof sample always lands as index 0, restarting a partial frame.
  always_comb begin
    in_ready   = !bank_full[wr_bank];
    accept     = in_valid && in_ready;
    wr_idx     = in_sof ? '0 : wr_cnt;
    resync     = accept && in_sof && (wr_cnt != '0);
    frame_done = accept && (wr_idx == LAST_IDX);
  end

  // Write side
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
      sync_err <= resync;
      if (accept) wr_cnt <= wr_idx + 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // NOTE: the sample buffers carry no reset; bank_full alone decides whether their contents are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_real[wr_bank][bitrev(wr_idx)] <= in_real;
      mem_img[wr_bank][bitrev(wr_idx)]  <= in_img;
    end
  end

  // Set and clear never hit the same bit: a full read bank blocks writes to it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      bank_full <= '0;
    end else begin
      if (frame_done) bank_full[wr_bank] <= 1'b1;
      if (rd_done)    bank_full[rd_bank] <= 1'b0;
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= state_next;
  end

  // Read FSM: next state, tracking "read bank full" so the first load needs no extra cycle
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:   if (frame_done && (wr_bank == rd_bank)) state_next = STREAM;
      STREAM: if (rd_done && !bank_full[~rd_bank] && !frame_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    load    = (state == STREAM) && (!out_valid || out_ready);
    rd_done = load && (rd_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_img   <= '0;
      out_idx   <= '0;
    end else if (load) begin
      rd_cnt    <= rd_cnt + 1'b1;
      if (rd_done) rd_bank <= ~rd_bank;
      out_valid <= 1'b1;
      out_last  <= rd_done;
      out_real  <= mem_real[rd_bank][rd_cnt];
      out_img   <= mem_img[rd_bank][rd_cnt];
      out_idx   <= rd_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: reference frame model feeding a
// scoreboard queue, a table-driven frame, and hand-written stall/resync/reset sequences.
module tb_fft_bitrev_reorder;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_sof, in_ready;
  logic [DW-1:0] in_real, in_img;
  logic          out_valid, out_ready, out_last, sync_err;
  logic [DW-1:0] out_real, out_img;
  logic [3:0]    out_idx;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .SEQ_LENGTH(16), .LOG2_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_sof(in_sof), .in_real(in_real), .in_img(in_img),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_img(out_img), .out_idx(out_idx),
    .out_last(out_last), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [3:0]    idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_img;
    logic [DW-1:0] exp_real;
    logic [DW-1:0] exp_img;
  } vec_t;

  exp_t          q[$];
  vec_t          tbl[16];
  int            n_vec = 0;
  int            n_miss = 0;
  int            n_out = 0;
  logic          tbl_mode = 1'b0;
  int            mcnt = 0;
  logic [DW-1:0] mfr_r[16];
  logic [DW-1:0] mfr_i[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev4(input int v);
    logic [3:0] a, b;
    a = 4'(v);
    for (int k = 0; k < 4; k++) b[k] = a[3-k];
    return int'(b);
  endfunction

  // Reference model: sample at write count c is bin rev4(c); a full frame pushes bins 0..15.
  task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic sof);
    if (sof) mcnt = 0;
    mfr_r[rev4(mcnt)] = r;
    mfr_i[rev4(mcnt)] = i;
    if (mcnt == 15) begin
      if (!tbl_mode)
        for (int n = 0; n < 16; n++) q.push_back('{mfr_r[n], mfr_i[n], 4'(n), n == 15});
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_sample(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic sof);
    int g = 0;
    in_valid = 1'b1; in_real = r; in_img = i; in_sof = sof;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0; in_sof = 1'b0;
      return;
    end
    model_accept(r, i, sof);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q.size() != 0 || out_valid) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    check("drain", {62'd0, q.size() == 0, !out_valid}, 64'd3);
  endtask

  // Output monitor, sampling on the falling edge for the handshake at the next rising edge.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] hold_r, hold_i;
  logic [3:0]    hold_idx;

  always @(negedge clk) begin
    if (reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", {out_real, out_img, out_idx}, {hold_r, hold_i, hold_idx});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", {out_real, out_img, out_idx}, 64'd0);
          n_miss++;
          n_vec++;
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", {out_real, out_img}, {e.r, e.i});
          check("out_idx_last", {out_idx, out_last}, {e.idx, e.last});
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      hold_r = out_real; hold_i = out_img; hold_idx = out_idx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [3:0] pat = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      tbl[k].in_real  = DW'(xs[k]);
      tbl[k].in_img   = DW'(-xs[k]);
      tbl[k].exp_real = DW'(k);
      tbl[k].exp_img  = DW'(-k);
    end

    reset_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_real = '0; in_img = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {out_valid, out_last, sync_err, in_ready, out_idx}, {4'b0001, 4'd0});
    check("reset_data", {out_real, out_img}, 64'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;

    // Ramp frame: value k at write count k, latency to first output
    for (int k = 0; k < 16; k++) push_sample(DW'(k), DW'(k), k == 0);
    check("latency_edge_E", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_edge_E1", {out_valid, out_idx}, {1'b1, 4'd0});
    wait_drain();

    // Table-driven frame: bit-reversed input yields natural order, signed imag preserved
    tbl_mode = 1'b1;
    for (int k = 0; k < 16; k++) q.push_back('{tbl[k].exp_real, tbl[k].exp_img, 4'(k), k == 15});
    for (int k = 0; k < 16; k++) push_sample(tbl[k].in_real, tbl[k].in_img, k == 0);
    tbl_mode = 1'b0;
    wait_drain();

    // Three frames with downstream stalled, then release
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) push_sample(DW'(300 + k), DW'(1000 - k), k % 16 == 0);
    check("both_full_in_ready", 64'(in_ready), 64'd0);
    fork
      begin
        for (int k = 0; k < 16; k++) push_sample(DW'(400 + k), DW'(2000 + k), k == 0);
      end
      begin
        int base;
        logic seen;
        repeat (10) begin @(posedge clk); #1; end
        check("stalled_in_ready", 64'(in_ready), 64'd0);
        base = n_out;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 48; c++) begin
          @(posedge clk); #1;
          if (in_ready) seen = 1'b1;
        end
        check("in_ready_returns", 64'(seen), 64'd1);
        check("gapless_48", 64'(n_out - base), 64'd48);
        check("after_48", {62'd0, out_valid, q.size() == 0}, 64'd1);
      end
    join
    wait_drain();

    // out_ready toggling 1,0,0,1
    fork
      for (int k = 0; k < 16; k++) push_sample(DW'(500 + k), DW'(-k), k == 0);
      for (int c = 0; c < 80; c++) begin
        out_ready = pat[3 - (c % 4)];
        @(posedge clk); #1;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Resync: in_sof at write count 5
    for (int k = 0; k < 5; k++) push_sample(DW'(600 + k), DW'(650 + k), k == 0);
    push_sample(DW'(700), DW'(750), 1'b1);
    check("sync_err_pulse", 64'(sync_err), 64'd1);
    @(posedge clk); #1;
    check("sync_err_single", 64'(sync_err), 64'd0);
    for (int k = 1; k < 16; k++) push_sample(DW'(700 + k), DW'(750 + k), 1'b0);
    wait_drain();

    // Reset mid-frame at out_idx 7
    for (int k = 0; k < 16; k++) push_sample(DW'(800 + k), DW'(850 + k), k == 0);
    begin
      int g = 0;
      while (!(out_valid && out_idx == 4'd7) && g < 50) begin
        @(posedge clk); #1; g++;
      end
      check("reach_idx7", {out_valid, out_idx}, {1'b1, 4'd7});
    end
    reset_n = 1'b1;
    q.delete();
    mcnt = 0;
    @(posedge clk); #1;
    check("midreset_state", {out_valid, in_ready, out_idx, sync_err}, {2'b01, 4'd0, 1'b0});
    reset_n = 1'b0;
    for (int k = 0; k < 16; k++) push_sample(DW'(900 + k), DW'(950 + k), k == 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
